// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// lcd_pkg : shared word type, HD44780 command codes and FSM states
// Rev 1.0
// ============================================================================
package lcd_pkg;

    typedef logic [8:0] palabra_t;

    localparam logic [7:0] CMD_FUNC  = 8'h38;
    localparam logic [7:0] CMD_DISP  = 8'h0C;
    localparam logic [7:0] CMD_ENTRY = 8'h06;
    localparam logic [7:0] CMD_CLR   = 8'h01;
    localparam logic [7:0] CMD_DDRAM = 8'h80;

    typedef enum logic [1:0] {
        POWER_WAIT = 2'd0,
        INIT       = 2'd1,
        IDLE       = 2'd2,
        UPDATE     = 2'd3
    } estado_t;

    typedef enum logic [1:0] {
        F_IDLE  = 2'd0,
        F_SETUP = 2'd1,
        F_PULSE = 2'd2,
        F_WAIT  = 2'd3
    } fase_t;

    function automatic palabra_t palabra_init(input logic [1:0] idx);
        palabra_t w;
        case (idx)
            2'd0:    w = {1'b0, CMD_FUNC};
            2'd1:    w = {1'b0, CMD_DISP};
            2'd2:    w = {1'b0, CMD_ENTRY};
            default: w = {1'b0, CMD_CLR};
        endcase
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_secuenciador_if.sv
`default_nettype none
// ============================================================================
// lcd_secuenciador_if : digit codes, update handshake and LCD pins
// Rev 1.0
// ============================================================================
interface lcd_secuenciador_if;
    import lcd_pkg::*;

    palabra_t    mostrar_cen;
    palabra_t    mostrar_dec;
    palabra_t    mostrar_uni;
    logic        actualizar;
    logic        ocupado;
    logic        listo;
    logic        lcd_rs;
    logic        lcd_rw;
    logic        lcd_e;
    logic [7:0]  lcd_data;

    modport master (
        output mostrar_cen, mostrar_dec, mostrar_uni, actualizar,
        input  ocupado, listo, lcd_rs, lcd_rw, lcd_e, lcd_data
    );

    modport slave (
        input  mostrar_cen, mostrar_dec, mostrar_uni, actualizar,
        output ocupado, listo, lcd_rs, lcd_rw, lcd_e, lcd_data
    );
endinterface
`default_nettype wire

// File: rtl/lcd_escritor.sv
`default_nettype none
// ============================================================================
// lcd_escritor : one LCD write (setup, E pulse, post-E wait)
// Rev 1.0
// ============================================================================
module lcd_escritor
    import lcd_pkg::*;
#(
    parameter int unsigned T_SU   = 2,
    parameter int unsigned T_E    = 12,
    parameter int unsigned T_WAIT = 2500,
    parameter int unsigned T_CLR  = 82000
) (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       inicio,
    input  wire palabra_t   palabra,
    input  wire logic       largo,
    output logic            lcd_e,
    output logic            lcd_rs,
    output logic [7:0]      lcd_data,
    output logic            hecho
);

    localparam int unsigned M1 = (T_SU > T_E) ? T_SU : T_E;
    localparam int unsigned M2 = (T_WAIT > T_CLR) ? T_WAIT : T_CLR;
    localparam int unsigned MX = (M1 > M2) ? M1 : M2;
    localparam int unsigned CW = (MX > 1) ? $clog2(MX) : 1;

    fase_t          fase_q, fase_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           largo_q, largo_d;
    logic           e_q, e_d;
    logic           rs_q, rs_d;
    logic [7:0]     data_q, data_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fase_q  <= F_IDLE;
            cnt_q   <= '0;
            largo_q <= 1'b0;
            e_q     <= 1'b0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            fase_q  <= fase_d;
            cnt_q   <= cnt_d;
            largo_q <= largo_d;
            e_q     <= e_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        fase_d  = fase_q;
        cnt_d   = cnt_q;
        largo_d = largo_q;
        e_d     = e_q;
        rs_d    = rs_q;
        data_d  = data_q;
        // Combinational so the next write can start on the very next cycle.
        hecho   = (fase_q == F_WAIT) && (cnt_q == '0);

        case (fase_q)
            F_SETUP: begin
                if (cnt_q == '0) begin
                    fase_d = F_PULSE;
                    cnt_d  = CW'(T_E - 1);
                    e_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            F_PULSE: begin
                if (cnt_q == '0) begin
                    fase_d = F_WAIT;
                    e_d    = 1'b0;
                    cnt_d  = largo_q ? CW'(T_CLR - 1) : CW'(T_WAIT - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            F_WAIT: begin
                if (cnt_q == '0) fase_d = F_IDLE;
                else             cnt_d  = cnt_q - 1'b1;
            end
            default: ;
        endcase

        if (inicio) begin
            fase_d  = F_SETUP;
            cnt_d   = CW'(T_SU - 1);
            largo_d = largo;
            e_d     = 1'b0;
            rs_d    = palabra[8];
            data_d  = palabra[7:0];
        end
    end

    assign lcd_e    = e_q;
    assign lcd_rs   = rs_q;
    assign lcd_data = data_q;

endmodule
`default_nettype wire

// File: rtl/lcd_secuenciador.sv
`default_nettype none
// ============================================================================
// lcd_secuenciador : HD44780 power-on init, then 3-digit updates on request
// Rev 1.0
// ============================================================================
module lcd_secuenciador
    import lcd_pkg::*;
#(
    parameter int unsigned T_POWER = 750000,
    parameter int unsigned T_SU    = 2,
    parameter int unsigned T_E     = 12,
    parameter int unsigned T_WAIT  = 2500,
    parameter int unsigned T_CLR   = 82000,
    parameter logic [6:0]  POS     = 7'h00
) (
    input  wire logic          clk,
    input  wire logic          rst,
    lcd_secuenciador_if.slave  bus
);

    localparam int unsigned PW = (T_POWER > 1) ? $clog2(T_POWER) : 1;

    estado_t        estado_q, estado_d;
    logic [PW-1:0]  pw_q, pw_d;
    logic [1:0]     idx_q, idx_d;
    logic           pendiente_q, pendiente_d;
    palabra_t       cen_q, cen_d, dec_q, dec_d, uni_q, uni_d;
    logic           ocupado_q, ocupado_d;
    logic           listo_q, listo_d;

    logic           inicio, largo, hecho;
    palabra_t       palabra;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q    <= POWER_WAIT;
            pw_q        <= '0;
            idx_q       <= 2'd0;
            pendiente_q <= 1'b0;
            cen_q       <= '0;
            dec_q       <= '0;
            uni_q       <= '0;
            ocupado_q   <= 1'b1;
            listo_q     <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            pw_q        <= pw_d;
            idx_q       <= idx_d;
            pendiente_q <= pendiente_d;
            cen_q       <= cen_d;
            dec_q       <= dec_d;
            uni_q       <= uni_d;
            ocupado_q   <= ocupado_d;
            listo_q     <= listo_d;
        end
    end

    always_comb begin
        estado_d    = estado_q;
        pw_d        = pw_q;
        idx_d       = idx_q;
        pendiente_d = pendiente_q;
        cen_d       = cen_q;
        dec_d       = dec_q;
        uni_d       = uni_q;
        inicio      = 1'b0;
        palabra     = '0;

        case (estado_q)
            POWER_WAIT: begin
                if (pw_q == PW'(T_POWER - 1)) begin
                    estado_d = INIT;
                    idx_d    = 2'd0;
                    inicio   = 1'b1;
                    palabra  = palabra_init(2'd0);
                end else begin
                    pw_d = pw_q + 1'b1;
                end
            end
            INIT: begin
                if (hecho) begin
                    if (idx_q == 2'd3) begin
                        estado_d = IDLE;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        inicio  = 1'b1;
                        palabra = palabra_init(idx_q + 2'd1);
                    end
                end
            end
            IDLE: begin
                // Codes are sampled here so an update shows the values current at its start.
                if (bus.actualizar || pendiente_q) begin
                    cen_d       = bus.mostrar_cen;
                    dec_d       = bus.mostrar_dec;
                    uni_d       = bus.mostrar_uni;
                    pendiente_d = 1'b0;
                    estado_d    = UPDATE;
                    idx_d       = 2'd0;
                    inicio      = 1'b1;
                    palabra     = {1'b0, CMD_DDRAM | {1'b0, POS}};
                end
            end
            default: begin
                if (hecho) begin
                    if (idx_q == 2'd3) begin
                        estado_d = IDLE;
                    end else begin
                        idx_d  = idx_q + 2'd1;
                        inicio = 1'b1;
                        case (idx_q)
                            2'd0:    palabra = cen_q;
                            2'd1:    palabra = dec_q;
                            default: palabra = uni_q;
                        endcase
                    end
                end
            end
        endcase

        if (bus.actualizar && (estado_q != IDLE)) pendiente_d = 1'b1;

        largo     = (palabra == {1'b0, CMD_CLR});
        ocupado_d = (estado_d != IDLE);
        listo_d   = listo_q || ((estado_q == INIT) && (estado_d == IDLE));
    end

    lcd_escritor #(
        .T_SU   (T_SU),
        .T_E    (T_E),
        .T_WAIT (T_WAIT),
        .T_CLR  (T_CLR)
    ) u_escritor (
        .clk      (clk),
        .rst      (rst),
        .inicio   (inicio),
        .palabra  (palabra),
        .largo    (largo),
        .lcd_e    (bus.lcd_e),
        .lcd_rs   (bus.lcd_rs),
        .lcd_data (bus.lcd_data),
        .hecho    (hecho)
    );

    assign bus.ocupado = ocupado_q;
    assign bus.listo   = listo_q;
    assign bus.lcd_rw  = 1'b0;

endmodule
`default_nettype wire
